vga_reg_loader: RTL and testbench
=================================

VGA_REG_LOADER -- requirements
Module: vga_reg_loader

Interface
REQ-001 DATA_WIDTH, 8, width of each control register and the data bus.
REQ-002 ADDR_BUS_WIDTH, 19, MMIO address bus width.
REQ-003 NUM_VGA_CONT_REG, 11, number of registers loaded (TIMR0-9, VGACR0); legal range 1-16.
REQ-004 clock  in  1  system clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle request to begin a load sequence.
REQ-007 init_values  in  NUM_VGA_CONT_REG*DATA_WIDTH  register images; register i occupies bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
REQ-008 bus_req  out  1  request for ownership of the shared MMIO bus.
REQ-009 bus_grant  in  1  arbiter grant; the loader drives bus cycles only while it is high.
REQ-010 addr_bus  out  ADDR_BUS_WIDTH  MMIO address.
REQ-011 data_bus  out  DATA_WIDTH  write data.
REQ-012 data_wen  out  1  write enable; 0 while addr_bus is valid means read.
REQ-013 data_bus_in  in  DATA_WIDTH  read data from the register bank, valid at the posedge after the read address cycle.
REQ-014 busy  out  1  high from the cycle after an accepted start until done.
REQ-015 done  out  1  one-cycle pulse at sequence completion.
REQ-016 error  out  1  sticky readback-mismatch flag, cleared by the next accepted start.
REQ-017 err_index  out  4  index of the first mismatching register.

Function
REQ-018 Register i SHALL be addressed at {1'b1, zeros, i[3:0]}, i.e. base 19'h40000 + i.
REQ-019 States SHALL be IDLE, ARB, WRITE, READ, CHECK, DONE.
REQ-020 IDLE: start=1 SHALL clear error/err_index, set index=0, go to ARB; start while not IDLE SHALL be ignored.
REQ-021 ARB: bus_req=1; on bus_grant=1 SHALL go to WRITE.
REQ-022 WRITE: each granted cycle SHALL drive addr=base+index, data_bus=init_values[index], data_wen=1, then increment index; after index NUM_VGA_CONT_REG-1 SHALL go to READ with index=0 (verify enabled) or DONE.
REQ-023 READ: SHALL drive addr=base+index with data_wen=0 for one cycle, then go to CHECK.
REQ-024 CHECK: SHALL compare data_bus_in with init_values[index]; on the first mismatch SHALL set error and capture err_index; later mismatches SHALL not alter err_index; SHALL go to READ with index+1, or to DONE after the last index.
REQ-025 DONE: SHALL pulse done for one cycle, drop bus_req, and return to IDLE.
REQ-026 bus_req SHALL stay high throughout ARB, WRITE, READ and CHECK.
REQ-027 Grant loss in WRITE/READ/CHECK SHALL freeze state and index, force data_wen=0, and resume the same index when grant returns.
REQ-028 When no granted bus cycle is active, addr_bus, data_bus and data_wen SHALL be 0.
REQ-029 init_values SHALL be sampled per access (not latched); it SHALL be held stable by the user while busy.

Reset
REQ-030 Asserting reset at any time, including mid-sequence, SHALL force IDLE, index=0, and all outputs to 0, with no done pulse.

Configuration
REQ-031 Macro VGA_REG_LOADER_VERIFY_EN defined: READ/CHECK readback pass is included.
REQ-032 Macro undefined: WRITE goes directly to DONE, error and err_index are tied to 0, and data_bus_in is unused.

Structure
REQ-033 A shared package SHALL hold the state encoding, the MMIO base constant 19'h40000, and the register index names TIMR0-TIMR9 and VGACR0.
REQ-034 The design SHALL be a single module with no sub-module.

Verification
REQ-035 start with grant tied high and values 8'h10..8'h1A -> 11 writes to 0x40000..0x4000A with matching data, then 11 reads, done at a fixed cycle, error=0.
REQ-036 Bank model corrupts register 3 (8'hFF) and register 7 -> error=1, err_index=3, done still pulses.
REQ-037 Grant dropped for 5 cycles after the 4th write -> data_wen=0 during the gap, resumes at 0x40004, no duplicate or skipped writes.
REQ-038 reset asserted during READ of index 5 -> all outputs 0 immediately, IDLE, no done; a subsequent start performs a full sequence.
REQ-039 start re-pulsed while busy -> ignored, exactly one done pulse.
REQ-040 Build without VGA_REG_LOADER_VERIFY_EN -> done one cycle after the last write, no read cycles, error=0.

Source files
------------

// File: rtl/vga_reg_loader_pkg.sv
// Shared definitions for the VGA control-register loader: state encoding,
// MMIO placement of the register bank and the names of the loaded registers.
package vga_reg_loader_pkg;

    localparam int VGA_DATA_WIDTH = 8;
    localparam int VGA_ADDR_WIDTH = 19;
    localparam int VGA_NUM_REGS   = 11;

    // The register bank sits in the upper half of the MMIO space.
    localparam logic [VGA_ADDR_WIDTH-1:0] MMIO_BASE = 19'h40000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        TIMR0  = 4'd0,
        TIMR1  = 4'd1,
        TIMR2  = 4'd2,
        TIMR3  = 4'd3,
        TIMR4  = 4'd4,
        TIMR5  = 4'd5,
        TIMR6  = 4'd6,
        TIMR7  = 4'd7,
        TIMR8  = 4'd8,
        TIMR9  = 4'd9,
        VGACR0 = 4'd10
    } vga_reg_e;

    function automatic logic [3:0] last_index(input int num_regs);
        return 4'(num_regs - 1);
    endfunction

endpackage

// File: rtl/vga_reg_loader_if.sv
// Shared MMIO bus between the register loader (master) and the arbiter /
// register bank side (slave).
interface vga_reg_loader_if
    import vga_reg_loader_pkg::*;
#(
    parameter int DATA_WIDTH     = VGA_DATA_WIDTH,
    parameter int ADDR_BUS_WIDTH = VGA_ADDR_WIDTH
);

    logic                      bus_req;
    logic                      bus_grant;
    logic [ADDR_BUS_WIDTH-1:0] addr_bus;
    logic [DATA_WIDTH-1:0]     data_bus;
    logic                      data_wen;
    logic [DATA_WIDTH-1:0]     data_bus_in;

    modport master (
        output bus_req,
        output addr_bus,
        output data_bus,
        output data_wen,
        input  bus_grant,
        input  data_bus_in
    );

    modport slave (
        input  bus_req,
        input  addr_bus,
        input  data_bus,
        input  data_wen,
        output bus_grant,
        output data_bus_in
    );

endinterface

// File: rtl/vga_reg_loader.sv
// Loads the VGA timing/control registers over the shared MMIO bus on request.
// Define VGA_REG_LOADER_VERIFY_EN to add a readback pass that flags mismatches.
module vga_reg_loader
    import vga_reg_loader_pkg::*;
#(
    parameter int DATA_WIDTH       = VGA_DATA_WIDTH,
    parameter int ADDR_BUS_WIDTH   = VGA_ADDR_WIDTH,
    parameter int NUM_VGA_CONT_REG = VGA_NUM_REGS
)(
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [NUM_VGA_CONT_REG*DATA_WIDTH-1:0] init_values,
    vga_reg_loader_if.master                     bus,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error,
    output logic [3:0]                           err_index
);

    localparam logic [3:0]                LAST_INDEX = last_index(NUM_VGA_CONT_REG);
    localparam logic [ADDR_BUS_WIDTH-1:0] BASE_ADDR  = ADDR_BUS_WIDTH'(MMIO_BASE);

    state_e          state;
    state_e          state_next;
    logic [3:0]      index;
    logic [3:0]      index_next;
    logic [DATA_WIDTH-1:0] cur_value;
    logic            granted;

`ifdef VGA_REG_LOADER_VERIFY_EN
    logic            error_q;
    logic            error_next;
    logic [3:0]      err_index_q;
    logic [3:0]      err_index_next;
    logic            mismatch;
`else
    logic            unused_data_bus_in;
`endif

    assign granted = bus.bus_grant;

    // init_values is read live each access rather than latched at start.
    always_comb begin
        cur_value = '0;
        for (int i = 0; i < NUM_VGA_CONT_REG; i++) begin
            if (index == 4'(i)) begin
                cur_value = init_values[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef VGA_REG_LOADER_VERIFY_EN
    assign mismatch = (bus.data_bus_in != cur_value);
`else
    assign unused_data_bus_in = ^bus.data_bus_in;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            index       <= '0;
`ifdef VGA_REG_LOADER_VERIFY_EN
            error_q     <= 1'b0;
            err_index_q <= '0;
`endif
        end else begin
            state       <= state_next;
            index       <= index_next;
`ifdef VGA_REG_LOADER_VERIFY_EN
            error_q     <= error_next;
            err_index_q <= err_index_next;
`endif
        end
    end

    // Losing the grant in any bus state simply holds state and index.
    always_comb begin
        state_next = state;
        index_next = index;
`ifdef VGA_REG_LOADER_VERIFY_EN
        error_next     = error_q;
        err_index_next = err_index_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ARB;
                    index_next = '0;
`ifdef VGA_REG_LOADER_VERIFY_EN
                    error_next     = 1'b0;
                    err_index_next = '0;
`endif
                end
            end
            ARB: begin
                if (granted) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (granted) begin
                    if (index == LAST_INDEX) begin
                        index_next = '0;
`ifdef VGA_REG_LOADER_VERIFY_EN
                        state_next = READ;
`else
                        state_next = DONE;
`endif
                    end else begin
                        index_next = index + 4'd1;
                    end
                end
            end
`ifdef VGA_REG_LOADER_VERIFY_EN
            READ: begin
                if (granted) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (granted) begin
                    if (mismatch && !error_q) begin
                        error_next     = 1'b1;
                        err_index_next = index;
                    end
                    if (index == LAST_INDEX) begin
                        index_next = '0;
                        state_next = DONE;
                    end else begin
                        index_next = index + 4'd1;
                        state_next = READ;
                    end
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
                index_next = '0;
            end
            default: begin
                state_next = IDLE;
                index_next = '0;
            end
        endcase
    end

    // Bus drives are zero whenever no granted write/read cycle is in progress.
    always_comb begin
        bus.bus_req  = (state == ARB) || (state == WRITE) ||
                       (state == READ) || (state == CHECK);
        bus.addr_bus = '0;
        bus.data_bus = '0;
        bus.data_wen = 1'b0;
        if (granted && state == WRITE) begin
            bus.addr_bus = BASE_ADDR | ADDR_BUS_WIDTH'(index);
            bus.data_bus = cur_value;
            bus.data_wen = 1'b1;
        end else if (granted && state == READ) begin
            bus.addr_bus = BASE_ADDR | ADDR_BUS_WIDTH'(index);
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

`ifdef VGA_REG_LOADER_VERIFY_EN
    assign error     = error_q;
    assign err_index = err_index_q;
`else
    assign error     = 1'b0;
    assign err_index = 4'd0;
`endif

endmodule

// File: tb/tb_vga_reg_loader.sv
// Directed bench for vga_reg_loader with a small register-bank and arbiter model;
// expectations follow VGA_REG_LOADER_VERIFY_EN.
module tb_vga_reg_loader;
    import vga_reg_loader_pkg::*;

    localparam int DW = 8;
    localparam int AW = 19;
    localparam int NR = 11;
`ifdef VGA_REG_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int LATENCY = VERIFY ? 35 : 13;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [NR*DW-1:0] init_values;
    logic             busy;
    logic             done;
    logic             error;
    logic [3:0]       err_index;
    logic             grant = 1'b1;
    logic [DW-1:0]    rdata = '0;
    logic [DW-1:0]    bank [16];
    bit               corrupt_en = 1'b0;

    int tests = 0;
    int fails = 0;
    int ncyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int gap_viol = 0;
    logic [AW-1:0] wr_addr [$];
    logic [DW-1:0] wr_data [$];
    logic [AW-1:0] rd_addr [$];

    vga_reg_loader_if #(.DATA_WIDTH(DW), .ADDR_BUS_WIDTH(AW)) bus ();

    vga_reg_loader #(
        .DATA_WIDTH(DW),
        .ADDR_BUS_WIDTH(AW),
        .NUM_VGA_CONT_REG(NR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .init_values(init_values),
        .bus(bus),
        .busy(busy),
        .done(done),
        .error(error),
        .err_index(err_index)
    );

    assign bus.bus_grant   = grant;
    assign bus.data_bus_in = rdata;

    always #5 clock = ~clock;

    // Register bank: registered read, with optional corruption of registers 3 and 7.
    always @(posedge clock) begin
        if (bus.data_wen) begin
            if (corrupt_en && bus.addr_bus[3:0] == 4'd3)
                bank[bus.addr_bus[3:0]] <= 8'hFF;
            else if (corrupt_en && bus.addr_bus[3:0] == 4'd7)
                bank[bus.addr_bus[3:0]] <= 8'h00;
            else
                bank[bus.addr_bus[3:0]] <= bus.data_bus;
        end
        if (bus.addr_bus[18] && !bus.data_wen)
            rdata <= bank[bus.addr_bus[3:0]];
    end

    always @(negedge clock) begin
        ncyc++;
        if (bus.data_wen) begin
            wr_addr.push_back(bus.addr_bus);
            wr_data.push_back(bus.data_bus);
        end else if (bus.addr_bus != '0) begin
            rd_addr.push_back(bus.addr_bus);
        end
        if (done) begin
            done_cnt++;
            done_cyc = ncyc;
        end
        if (!grant && (bus.data_wen || bus.addr_bus != '0 || bus.data_bus != '0))
            gap_viol++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearLog();
        wr_addr.delete();
        wr_data.delete();
        rd_addr.delete();
    endtask

    task automatic applyStimulus();
        @(negedge clock);
        #1;
        start     = 1'b1;
        start_cyc = ncyc;
        @(negedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget, input int settle);
        int base;
        int n;
        base = done_cnt;
        n    = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        repeat (settle) @(negedge clock);
        #1;
        checkOutput({tag, "_done_pulses"}, done_cnt - base, 1);
    endtask

    // Checks the write log holds exactly one ordered write per register.
    task automatic checkWriteLog(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++) begin
            if (wr_addr[i] != (AW'(MMIO_BASE) | AW'(i)) || wr_data[i] != DW'(8'h10 + i))
                bad++;
        end
        checkOutput({tag, "_wr_count"}, wr_addr.size(), NR);
        checkOutput({tag, "_wr_order"}, bad, 0);
    endtask

    initial begin
        int n;
        bit hit;
        int base;
        int rd_bad;

        for (int i = 0; i < NR; i++)
            init_values[i*DW +: DW] = DW'(8'h10 + i);

        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checkOutput("rst_bus_req", bus.bus_req, 0);
        checkOutput("rst_data_wen", bus.data_wen, 0);
        checkOutput("rst_addr", bus.addr_bus, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_error", error, 0);
        reset = 1'b1;

        // Clean load with grant held high.
        clearLog();
        applyStimulus();
        checkOutput("basic_busy", busy, 1);
        checkOutput("basic_bus_req", bus.bus_req, 1);
        waitDone("basic", 100, 4);
        checkOutput("basic_latency", done_cyc - start_cyc, LATENCY);
        checkOutput("basic_wr_count", wr_addr.size(), NR);
        for (int i = 0; i < wr_addr.size(); i++) begin
            checkOutput($sformatf("basic_wr_addr%0d", i), wr_addr[i], 32'h40000 + i);
            checkOutput($sformatf("basic_wr_data%0d", i), wr_data[i], 32'h10 + i);
        end
        rd_bad = 0;
        for (int i = 0; i < rd_addr.size(); i++)
            if (rd_addr[i] != (AW'(MMIO_BASE) | AW'(i))) rd_bad++;
        checkOutput("basic_rd_count", rd_addr.size(), VERIFY ? NR : 0);
        checkOutput("basic_rd_order", rd_bad, 0);
        checkOutput("basic_error", error, 0);
        checkOutput("basic_busy_end", busy, 0);
        checkOutput("basic_bus_req_end", bus.bus_req, 0);

        // Bank corrupts registers 3 and 7; only the first is reported.
        corrupt_en = 1'b1;
        clearLog();
        applyStimulus();
        waitDone("corrupt", 100, 4);
        checkOutput("corrupt_error", error, VERIFY ? 1 : 0);
        checkOutput("corrupt_err_index", err_index, VERIFY ? 3 : 0);
        checkOutput("corrupt_latency", done_cyc - start_cyc, LATENCY);

        // Next start clears the sticky error; grant then drops after the 4th write.
        corrupt_en = 1'b0;
        clearLog();
        applyStimulus();
        checkOutput("restart_clears_error", error, 0);
        checkOutput("restart_clears_err_index", err_index, 0);
        n = 0;
        while (wr_addr.size() < 4 && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        checkOutput("gap_reached_4th_write", wr_addr.size(), 4);
        @(posedge clock);
        #1;
        grant = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        grant = 1'b1;
        waitDone("gap", 100, 4);
        checkWriteLog("gap");
        checkOutput("gap_outputs_idle", gap_viol, 0);
        checkOutput("gap_latency", done_cyc - start_cyc, LATENCY + 5);
        checkOutput("gap_error", error, 0);

        // Reset lands while register 5 is on the bus (read pass, or write pass without it).
        corrupt_en = 1'b1;
        clearLog();
        applyStimulus();
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 100) begin
            @(negedge clock);
            #1;
            n++;
            hit = VERIFY ? (rd_addr.size() > 0 && rd_addr[$] == 19'h40005)
                         : (wr_addr.size() > 0 && wr_addr[$] == 19'h40005);
        end
        checkOutput("midrst_reached_index5", hit, 1);
        checkOutput("midrst_pre_error", error, VERIFY ? 1 : 0);
        base  = done_cnt;
        reset = 1'b0;
        #1;
        checkOutput("midrst_bus_req", bus.bus_req, 0);
        checkOutput("midrst_addr", bus.addr_bus, 0);
        checkOutput("midrst_data", bus.data_bus, 0);
        checkOutput("midrst_data_wen", bus.data_wen, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_error", error, 0);
        checkOutput("midrst_err_index", err_index, 0);
        repeat (5) @(negedge clock);
        #1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checkOutput("midrst_no_done", done_cnt - base, 0);
        checkOutput("midrst_idle_after", busy, 0);
        corrupt_en = 1'b0;
        clearLog();
        applyStimulus();
        waitDone("postrst", 100, 4);
        checkWriteLog("postrst");
        checkOutput("postrst_latency", done_cyc - start_cyc, LATENCY);
        checkOutput("postrst_error", error, 0);

        // Extra start pulses while busy must not restart or extend the sequence.
        clearLog();
        applyStimulus();
        repeat (3) @(negedge clock);
        #1;
        start = 1'b1;
        @(negedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        start = 1'b1;
        @(negedge clock);
        #1;
        start = 1'b0;
        waitDone("repulse", 100, 50);
        checkWriteLog("repulse");
        checkOutput("repulse_latency", done_cyc - start_cyc, LATENCY);
        checkOutput("repulse_busy_end", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
